// File: rtl/fpu_dp_divider_seq.sv
// fpu_dp_divider_seq: multicycle IEEE-754 binary64 divider (result = a / b).
// Radix-2 restoring mantissa division, one quotient bit per clock, RNE
// rounding, subnormals flushed to zero on input and output.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start                    - launch request, honoured only in IDLE
//   a, b                     - dividend / divisor, latched on the accepting edge
//   busy                     - high from the accepting edge through the done cycle
//   done                     - one-cycle pulse, result and flags valid
//   result                   - binary64 quotient
//   overflow_underflow_flag  - result saturated to infinity or flushed to zero
//   div_by_zero              - finite nonzero value divided by zero
module fpu_dp_divider_seq #(
  parameter int unsigned QBITS = 56
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        overflow_underflow_flag,
  output logic        div_by_zero
);

  localparam int unsigned CW = $clog2(QBITS);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_DIVIDE, S_NORM, S_DONE
  } state_t;

  state_t             r_state, w_state_nx;
  logic [63:0]        r_a, r_b;
  logic               r_sign;
  logic signed [12:0] r_exp;
  logic [53:0]        r_rem;
  logic [52:0]        r_div;
  logic [QBITS-1:0]   r_q;
  logic [CW-1:0]      r_cnt;
  logic [63:0]        r_result;
  logic               r_ovf, r_dz;

  // Operand decode (exponent 0 means zero, subnormals flushed)
  logic [10:0] w_ea, w_eb;
  logic [51:0] w_ma, w_mb;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sign;
  assign w_ea     = r_a[62:52];
  assign w_eb     = r_b[62:52];
  assign w_ma     = r_a[51:0];
  assign w_mb     = r_b[51:0];
  assign w_sign   = r_a[63] ^ r_b[63];
  assign w_a_zero = (w_ea == 11'd0);
  assign w_b_zero = (w_eb == 11'd0);
  assign w_a_inf  = (w_ea == 11'h7FF) && (w_ma == '0);
  assign w_b_inf  = (w_eb == 11'h7FF) && (w_mb == '0);
  assign w_a_nan  = (w_ea == 11'h7FF) && (w_ma != '0);
  assign w_b_nan  = (w_eb == 11'h7FF) && (w_mb != '0);

  logic        w_special, w_spec_dz;
  logic [63:0] w_spec_res;
  always_comb begin
    w_special  = 1'b1;
    w_spec_dz  = 1'b0;
    w_spec_res = '0;
    if (w_a_nan || w_b_nan)
      w_spec_res = 64'h7FF8_0000_0000_0000;
    else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
      w_spec_res = 64'h7FF8_0000_0000_0000;
    else if (w_b_zero && !w_a_inf) begin
      w_spec_res = {w_sign, 11'h7FF, 52'd0};
      w_spec_dz  = 1'b1;
    end else if (w_a_inf)
      w_spec_res = {w_sign, 11'h7FF, 52'd0};
    else if (w_a_zero || w_b_inf)
      w_spec_res = {w_sign, 63'd0};
    else
      w_special = 1'b0;
  end

  // One restoring division step
  logic        w_ge;
  logic [53:0] w_rem_sel;
  assign w_ge      = (r_rem >= {1'b0, r_div});
  assign w_rem_sel = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

  // Normalise and round. Quotient MSB has weight 1; the ratio lies in (0.5, 2).
  logic [QBITS-1:0]   w_qn;
  logic signed [12:0] w_exp_dec, w_exp_fin;
  logic [52:0]        w_mant;
  logic               w_g, w_r, w_s, w_up;
  logic [53:0]        w_mr;
  logic [51:0]        w_frac;
  always_comb begin
    w_qn      = r_q[QBITS-1] ? r_q : {r_q[QBITS-2:0], 1'b0};
    w_exp_dec = r_q[QBITS-1] ? r_exp : (r_exp - 13'sd1);
    w_mant    = w_qn[QBITS-1 -: 53];
    w_g       = w_qn[QBITS-54];
    w_r       = w_qn[QBITS-55];
    w_s       = (|w_qn[QBITS-56:0]) || (r_rem != '0);
    w_up      = w_g && (w_r || w_s || w_mant[0]);
    w_mr      = {1'b0, w_mant} + 54'(w_up);
    // Carry out of the mantissa leaves 1.000..0: shift right, bump exponent
    w_frac    = w_mr[53] ? w_mr[52:1] : w_mr[51:0];
    w_exp_fin = w_mr[53] ? (w_exp_dec + 13'sd1) : w_exp_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    case (r_state)
      S_IDLE:   if (start) w_state_nx = S_SETUP;
      S_SETUP:  w_state_nx = w_special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (r_cnt == CW'(QBITS-1)) w_state_nx = S_NORM;
      S_NORM:   w_state_nx = S_DONE;
      S_DONE:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= a;
          r_b   <= b;
          r_ovf <= 1'b0;
          r_dz  <= 1'b0;
        end
        S_SETUP: begin
          r_sign <= w_sign;
          r_exp  <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 13'sd1023;
          r_rem  <= {2'b01, w_ma};
          r_div  <= {1'b1, w_mb};
          r_cnt  <= '0;
          r_q    <= '0;
          if (w_special) begin
            r_result <= w_spec_res;
            r_dz     <= w_spec_dz;
          end
        end
        S_DIVIDE: begin
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_rem <= {w_rem_sel[52:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        S_NORM: begin
          if (w_exp_fin >= 13'sd2047) begin
            r_result <= {r_sign, 11'h7FF, 52'd0};
            r_ovf    <= 1'b1;
          end else if (w_exp_fin <= 13'sd0) begin
            r_result <= {r_sign, 63'd0};
            r_ovf    <= 1'b1;
          end else begin
            r_result <= {r_sign, w_exp_fin[10:0], w_frac};
          end
        end
        default: ;
      endcase
    end
  end

  assign result                  = r_result;
  assign overflow_underflow_flag = r_ovf;
  assign div_by_zero             = r_dz;

endmodule

// File: doc/fpu_dp_divider_seq.md
Name:
fpu_dp_divider_seq

Overview:
- Multicycle IEEE-754 binary64 divider, result = a / b. Companion to the combinational fpu_dp_adder in the FPU datapath.
- Radix-2 restoring mantissa division, one quotient bit per clock.
- Start/done handshake so the FPU issue logic can launch a divide and collect the result later.
- Rounding is round-to-nearest-even. Subnormals are flushed to zero on input and on output.

Parameters:
- QBITS, 56, number of quotient bits generated: 1 integer + 52 fraction + guard + round + 1 extra for normalisation.

Ports:
- clk  in  1  single clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request. Sampled only while busy=0.
- a  in  64  dividend, binary64. Sampled on the accepting edge.
- b  in  64  divisor, binary64. Sampled on the accepting edge.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse. result and flags are valid in this cycle.
- result  out  64  quotient, binary64.
- overflow_underflow_flag  out  1  set when the result overflowed to infinity or underflowed to zero.
- div_by_zero  out  1  set when a finite nonzero value is divided by zero.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, result=0, overflow_underflow_flag=0, div_by_zero=0. FSM goes to IDLE.
- States: IDLE -> SETUP -> DIVIDE -> NORM_ROUND -> DONE -> IDLE.
- IDLE:
  - Edge with start=1 latches a and b, sets busy=1, goes to SETUP.
  - start while busy=1 is ignored: no queueing, latched operands unchanged.
- SETUP, one edge:
  - Unpack both operands. Exponent 0 is treated as zero.
  - sign = sa ^ sb.
  - exp = ea - eb + 1023, held in a 13-bit signed register.
  - Load remainder = {1,ma}, divisor = {1,mb}, counter = 0.
  - If a special case applies, write result and flags and go straight to DONE.
- Special cases (in priority order):
  - Either input NaN -> 0x7FF8000000000000.
  - 0/0 or inf/inf -> 0x7FF8000000000000.
  - finite nonzero / 0 -> signed inf, div_by_zero=1.
  - inf/x -> signed inf.
  - 0/x or x/inf -> signed zero.
  - The flag is 0 in all special cases.
- DIVIDE, QBITS edges, one quotient bit per edge:
  - If remainder >= divisor, set the quotient bit and subtract.
  - Shift the remainder left by 1.
  - counter increments; leave DIVIDE when counter = QBITS-1.
- NORM_ROUND, one edge:
  - If quotient MSB = 0 (mantissa ratio < 1), shift left 1 and decrement exp.
  - sticky = (remainder != 0) OR'd with bits below round.
  - Apply RNE. If rounding carries out the mantissa, shift right and increment exp.
  - exp >= 2047 -> signed inf, flag=1.
  - exp <= 0 -> signed zero, flag=1.
- DONE, one cycle:
  - done=1, busy=0 on exit, return to IDLE.
  - result and flags hold until the next accepted start's done.
  - A start in the DONE cycle is ignored; it must be reissued in IDLE.
- Latency, counting the accepting edge as edge 1:
  - Normal operands: done is high after edge 59 (1 SETUP + 56 DIVIDE + 1 NORM_ROUND + 1).
  - Special cases: done is high after edge 2.
- Reset mid-operation: abort and return to IDLE. No done pulse. All outputs take reset values.
- Flags are cleared at each accept and rewritten only at DONE.

Test Plan:
- 6.0/2.0 (0x4018000000000000 / 0x4000000000000000) -> done exactly after edge 59, result 0x4008000000000000, both flags 0. busy is high edges 1-59.
- 1.0/3.0 -> 0x3FD5555555555555. 2.0/3.0 -> 0x3FE5555555555555. -1.0/4.0 -> 0xBFD0000000000000. Checks RNE and sign.
- 1.0/0.0 -> 0x7FF0000000000000, div_by_zero=1, done after edge 2.
- 0.0/0.0 -> 0x7FF8000000000000, div_by_zero=0.
- 1e308/1e-10 -> 0x7FF0000000000000, flag=1.
- 1e-300/1e300 -> 0x0000000000000000, flag=1.
- Reset at edge 30 of 6.0/2.0 -> no done, outputs 0, IDLE on the next edge.
- start pulsed at edge 10 with a different a during a divide -> ignored; first result unchanged.
- Then a new start in IDLE -> accepted normally.
